// File: rtl/sound_cmd_mailbox.sv
// Sound command mailbox: the main CPU queues command bytes in a small FIFO
// that the sound CPU drains. The sound CPU answers through a one-byte
// response latch. A status byte is visible to both sides, and an NMI
// generator pulses the sound CPU once for each pending command.
module sound_cmd_mailbox #(
    parameter int DEPTH   = 4,
    parameter int NMI_GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       main_wr_b,
    input  logic       main_rd_b,
    input  logic [7:0] main_din,
    output logic [7:0] main_dout,
    output logic [7:0] main_status,
    input  logic       WR68k_b,
    input  logic       RD68k_b,
    input  logic       SBA0,
    input  logic [7:0] SDout,
    output logic [7:0] snd_dout,
    output logic       snd_dout_en,
    output logic       SNDNMI_b
);

    // The count is five bits wide so that it can hold DEPTH = 16.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 5;
    localparam int GAP_W = (NMI_GAP > 1) ? $clog2(NMI_GAP + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } nmi_state_t;

    // Strobe history. Each register resets to 0 ("already low"), so a strobe
    // that is still held low when reset is released is ignored until it
    // rises and falls again.
    logic             r_main_wr_q;
    logic             r_main_rd_q;
    logic             r_snd_wr_q;
    logic             r_snd_rd_q;

    // Command FIFO
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // Response latch
    logic [7:0]       r_resp;
    logic             r_resp_full;

    // Registered read ports
    logic [7:0]       r_main_dout;
    logic [7:0]       r_snd_dout;

    // NMI generator
    nmi_state_t       r_state;
    logic             r_nmi_b;
    logic [GAP_W-1:0] r_gap_cnt;

    // Single-cycle strobe events and derived FIFO controls
    logic             w_main_wr_ev;
    logic             w_main_rd_ev;
    logic             w_snd_wr_ev;
    logic             w_snd_rd_ev;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [7:0]       w_status;

    // Each strobe fires once, on the first clock edge at which it is sampled low.
    assign w_main_wr_ev = r_main_wr_q & ~main_wr_b;
    assign w_main_rd_ev = r_main_rd_q & ~main_rd_b;
    assign w_snd_wr_ev  = r_snd_wr_q  & ~WR68k_b;
    assign w_snd_rd_ev  = r_snd_rd_q  & ~RD68k_b;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // The pop is resolved before the push. A full FIFO therefore still
    // accepts a write in the same cycle as a read. An empty FIFO never
    // forwards the incoming byte straight to the reader.
    assign w_pop  = w_snd_rd_ev & ~SBA0 & ~w_empty;
    assign w_push = w_main_wr_ev & (~w_full | w_pop);
    assign w_drop = w_main_wr_ev & w_full & ~w_pop;

    assign w_status    = {r_resp_full, ~w_empty, w_full, r_overflow, r_count[3:0]};
    assign main_status = w_status;
    assign main_dout   = r_main_dout;
    assign snd_dout    = r_snd_dout;
    assign snd_dout_en = ~RD68k_b;
    assign SNDNMI_b    = r_nmi_b;

    // Record each strobe's level from the previous cycle for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_wr_q <= 1'b0;
            r_main_rd_q <= 1'b0;
            r_snd_wr_q  <= 1'b0;
            r_snd_rd_q  <= 1'b0;
        end else begin
            r_main_wr_q <= main_wr_b;
            r_main_rd_q <= main_rd_b;
            r_snd_wr_q  <= WR68k_b;
            r_snd_rd_q  <= RD68k_b;
        end
    end

    // Move the FIFO pointers and occupancy count on push and pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write accepted command bytes into FIFO storage; the storage itself needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= main_din;
        end
    end

    // Keep the overflow flag set until the sound CPU writes a 1 to control bit 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_snd_wr_ev && SBA0 && SDout[0]) begin
            r_overflow <= 1'b0;
        end
    end

    // Sound-side read port: pop the FIFO head (0xFF when empty) or sample the status byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snd_dout <= 8'hFF;
        end else if (w_snd_rd_ev) begin
            if (SBA0) begin
                r_snd_dout <= w_status;
            end else if (w_empty) begin
                r_snd_dout <= 8'hFF;
            end else begin
                r_snd_dout <= r_mem[r_rd_ptr];
            end
        end
    end

    // Capture the sound CPU's response byte; later writes overwrite earlier ones.
    always_ff @(posedge clk) begin
        if (w_snd_wr_ev && !SBA0) begin
            r_resp <= SDout;
        end
    end

    // Track whether an unread response is waiting. A new response takes
    // precedence over a main read in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_full <= 1'b0;
        end else if (w_snd_wr_ev && !SBA0) begin
            r_resp_full <= 1'b1;
        end else if (w_main_rd_ev) begin
            r_resp_full <= 1'b0;
        end
    end

    // Main-side read port: return the pending response, or 0xFF if none is waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_dout <= 8'hFF;
        end else if (w_main_rd_ev) begin
            r_main_dout <= r_resp_full ? r_resp : 8'hFF;
        end
    end

    // NMI generator: hold NMI low while a command waits, release it for NMI_GAP cycles after each pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_nmi_b   <= 1'b1;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state <= ASSERT;
                        r_nmi_b <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (w_pop) begin
                        r_state   <= GAP;
                        r_nmi_b   <= 1'b1;
                        r_gap_cnt <= GAP_W'(NMI_GAP - 1);
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        if (!w_empty) begin
                            r_state <= ASSERT;
                            r_nmi_b <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_nmi_b <= 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_nmi_b <= 1'b1;
                end
            endcase
        end
    end

endmodule
